// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Receive controller state; encoding is fixed so it can be probed by firmware debug.
    typedef enum logic [1:0] {
        OFF   = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } rx_state_t;

    // 100 MHz clock, 9600 baud, 16x oversampling.
    localparam int DEF_DVSR        = 650;
    // Ten bit times at 16x oversampling.
    localparam int DEF_DRAIN_TICKS = 160;

    // Number of FIFO entries for a given address width.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word fall-through byte FIFO for received characters.
// Latency: a push or pop is visible on r_data/empty/full one clock later.
// Backpressure: writes while full are ignored unless a read happens in the same cycle; reads while empty are ignored.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] w_data,
    input  logic       rd,
    output logic [7:0] r_data,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = fifo_depth(FIFO_AW);

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] w_ptr;
    logic [FIFO_AW:0] r_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB separates the full case from the empty case.
    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[FIFO_AW] != r_ptr[FIFO_AW]) &&
                   (w_ptr[FIFO_AW-1:0] == r_ptr[FIFO_AW-1:0]);

    // A simultaneous pop frees the slot being written, so full does not block it.
    assign do_wr = wr && (!full || rd);
    assign do_rd = rd && !empty;

    assign r_data = mem[r_ptr[FIFO_AW-1:0]];

    // Storage and pointer update; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[w_ptr[FIFO_AW-1:0]] <= w_data;
                w_ptr                   <= w_ptr + 1'b1;
            end
            if (do_rd) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: baud tick generation, enable/drain FSM, byte capture FIFO with overrun status.
// Latency: s_tick is combinational from the tick counter; captured bytes reach r_data one clock after rx_done_tick.
// Backpressure: none toward the receiver; bytes arriving while the FIFO is full are dropped and flagged.
// Optional: define UART_RX_DROP_CNT_EN to build the saturating dropped-byte counter on drop_cnt.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT        = 8,
    parameter int DVSR_W      = 11,
    parameter int DVSR_DEF    = DEF_DVSR,
    parameter int FIFO_AW     = 2,
    parameter int DRAIN_TICKS = DEF_DRAIN_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_en,
    input  logic              dvsr_wr,
    input  logic [DVSR_W-1:0] dvsr_in,
    output logic              s_tick,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    input  logic              rd_uart,
    output logic [7:0]        r_data,
    output logic              rx_empty,
    output logic              rx_full,
    output logic              overrun,
    input  logic              clr_overrun,
    output logic [7:0]        drop_cnt
);

    localparam int         DRW       = $clog2(DRAIN_TICKS + 1);
    // Narrow frames leave the upper receiver bits undefined; keep them out of the FIFO.
    localparam logic [7:0] DATA_MASK = 8'((1 << DBIT) - 1);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [DVSR_W-1:0] dvsr;
    logic [DVSR_W-1:0] tick_cnt;
    logic [DRW-1:0]    drain_cnt;
    logic [DRW-1:0]    drain_nxt;
    logic              running;
    logic              drain_hit;
    logic              push;
    logic              drop;

    assign running = (state != OFF);

    // A divisor write restarts the period, so it never produces a tick itself.
    assign s_tick = running && !dvsr_wr && (tick_cnt == dvsr);

    // Baud divisor register and 0..dvsr tick counter, parked at 0 while off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvsr     <= DVSR_W'(DVSR_DEF);
            tick_cnt <= '0;
        end else if (dvsr_wr) begin
            dvsr     <= dvsr_in;
            tick_cnt <= '0;
        end else if (!running || (tick_cnt == dvsr)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // The drain limit fires on the edge that consumes the last allowed tick, so no extra tick leaks out.
    assign drain_nxt = drain_cnt + DRW'(s_tick);
    assign drain_hit = (drain_nxt == DRW'(DRAIN_TICKS));

    // Ticks spent in DRAIN; cleared in every other state so each entry starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (state != DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_nxt;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and capture enable; a finished byte ends DRAIN even if rx_en comes back.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            OFF: begin
                if (rx_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                push = rx_done_tick;
                if (!rx_en) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                push = rx_done_tick;
                if (rx_done_tick || drain_hit) begin
                    state_nxt = OFF;
                end else if (rx_en) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = OFF;
            end
        endcase
    end

    // A pop in the same cycle makes room, so only a push into a full FIFO without a pop is lost.
    assign drop = push && rx_full && !rd_uart;

    uart_rx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (push),
        .w_data (rx_data & DATA_MASK),
        .rd     (rd_uart),
        .r_data (r_data),
        .empty  (rx_empty),
        .full   (rx_full)
    );

    // Sticky overrun flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    // Saturating dropped-byte count; a drop in the clearing cycle restarts it at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            if (clr_overrun) begin
                drop_cnt_q <= 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end else if (clr_overrun) begin
            drop_cnt_q <= '0;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule
